// File: rtl/vector_pair_dot_product.sv
// rtl/vector_pair_dot_product.sv - pairs first/second vectors and streams their unsigned dot products
module vector_pair_dot_product #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int ADDR_WIDTH       = 17,
  parameter int VECTOR_DIMENSION = 3,
  parameter int RESULT_WIDTH     = 2*ELEMENT_WIDTH + $clog2(VECTOR_DIMENSION+1)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] first_vector,
  input  logic                                           first_vector_ready,
  input  logic [VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] second_vector,
  input  logic                                           second_vector_ready,
  input  logic                                           src_done,
  output logic [RESULT_WIDTH-1:0]                        result_data,
  output logic [ADDR_WIDTH-1:0]                          result_addr,
  output logic                                           result_valid,
  input  logic                                           result_ready,
  output logic [ADDR_WIDTH-1:0]                          result_count,
  output logic                                           overrun,
  output logic                                           busy,
  output logic                                           all_done
);

  localparam int IDX_W = (VECTOR_DIMENSION > 1) ? $clog2(VECTOR_DIMENSION) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_DIMENSION - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state;

  // Holding registers: one slot per side, filled while the engine is computing
  logic [VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] hold_a;
  logic [VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] hold_b;
  logic                                           full_a;
  logic                                           full_b;
  logic                                           done_latch;

  // Work registers owned by the MAC engine
  logic [VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] work_a;
  logic [VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] work_b;
  logic [RESULT_WIDTH-1:0]                        acc;
  logic [IDX_W-1:0]                               idx;

  logic [2*ELEMENT_WIDTH-1:0] product;
  logic [RESULT_WIDTH-1:0]    mac_sum;
  logic                       load;

  // The engine drains both holding registers in the same edge it starts a pair
  assign load     = (state == IDLE) && full_a && full_b;
  assign busy     = (state != IDLE);
  assign all_done = done_latch && !full_a && !full_b && (state == IDLE);

  // Full-width product of the current element pair added to the running sum
  always_comb begin
    product = work_a[idx] * work_b[idx];
    mac_sum = acc + RESULT_WIDTH'(product);
  end

  // Input capture: a strobe fills an empty slot (or one being drained), else it is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a     <= '0;
      hold_b     <= '0;
      full_a     <= 1'b0;
      full_b     <= 1'b0;
      overrun    <= 1'b0;
      done_latch <= 1'b0;
    end else begin
      if (load) begin
        full_a <= 1'b0;
        full_b <= 1'b0;
      end
      if (first_vector_ready) begin
        if (!full_a || load) begin
          hold_a <= first_vector;
          full_a <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (second_vector_ready) begin
        if (!full_b || load) begin
          hold_b <= second_vector;
          full_b <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (src_done) begin
        done_latch <= 1'b1;
      end
    end
  end

  // Engine: load a pair, accumulate one element per cycle, then hold the result until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      work_a       <= '0;
      work_b       <= '0;
      acc          <= '0;
      idx          <= '0;
      result_data  <= '0;
      result_valid <= 1'b0;
      result_addr  <= '0;
      result_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            work_a <= hold_a;
            work_b <= hold_b;
            acc    <= '0;
            idx    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= mac_sum;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            result_data  <= mac_sum;
            result_valid <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            result_addr  <= result_addr + 1'b1;
            result_count <= result_count + 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_pair_dot_product.sv
// tb/tb_vector_pair_dot_product.sv - directed self-checking bench for vector_pair_dot_product
module tb_vector_pair_dot_product;

  localparam int EW = 24;
  localparam int AW = 17;
  localparam int VD = 3;
  localparam int RW = 2*EW + $clog2(VD+1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [VD-1:0][EW-1:0]  first_vector;
  logic                   first_vector_ready;
  logic [VD-1:0][EW-1:0]  second_vector;
  logic                   second_vector_ready;
  logic                   src_done;
  logic [RW-1:0]          result_data;
  logic [AW-1:0]          result_addr;
  logic                   result_valid;
  logic                   result_ready;
  logic [AW-1:0]          result_count;
  logic                   overrun;
  logic                   busy;
  logic                   all_done;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic saw_valid;

  vector_pair_dot_product #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(VD)
  ) dut (
    .clk(clk), .reset(reset),
    .first_vector(first_vector), .first_vector_ready(first_vector_ready),
    .second_vector(second_vector), .second_vector_ready(second_vector_ready),
    .src_done(src_done),
    .result_data(result_data), .result_addr(result_addr), .result_valid(result_valid),
    .result_ready(result_ready), .result_count(result_count),
    .overrun(overrun), .busy(busy), .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    first_vector_ready = 1'b0;
    second_vector_ready = 1'b0;
    src_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic strobe_first(input logic [EW-1:0] a0, input logic [EW-1:0] a1, input logic [EW-1:0] a2);
    first_vector = {a2, a1, a0};
    first_vector_ready = 1'b1;
    tick();
    first_vector_ready = 1'b0;
  endtask

  task automatic strobe_second(input logic [EW-1:0] b0, input logic [EW-1:0] b1, input logic [EW-1:0] b2);
    second_vector = {b2, b1, b0};
    second_vector_ready = 1'b1;
    tick();
    second_vector_ready = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!result_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    first_vector = '0;
    second_vector = '0;
    result_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid", result_valid, 0);
    check("rst_data", result_data, 0);
    check("rst_addr", result_addr, 0);
    check("rst_count", result_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_all_done", all_done, 0);

    // Basic: (1,2,3).(4,5,6) = 32, valid 4 edges after the second strobe
    result_ready = 1'b1;
    strobe_first(1, 2, 3);
    strobe_second(4, 5, 6);
    check("basic_busy_idle_before_load", busy, 0);
    wait_result(lat);
    check("basic_latency", lat, 4);
    check("basic_data", result_data, 32);
    check("basic_addr", result_addr, 0);
    tick();
    check("basic_valid_drop", result_valid, 0);
    check("basic_count", result_count, 1);
    check("basic_addr_next", result_addr, 1);

    // Max values: 3*(2^24-1)^2 fits exactly in 50 bits
    do_reset();
    result_ready = 1'b1;
    strobe_first(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    strobe_second(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    wait_result(lat);
    check("max_valid", result_valid, 1);
    check("max_data", result_data, 64'd844424829468675);
    tick();

    // Backpressure: first result held while the next pair queues up
    do_reset();
    result_ready = 1'b0;
    strobe_first(1, 2, 3);
    strobe_second(4, 5, 6);
    wait_result(lat);
    check("bp_valid", result_valid, 1);
    strobe_first(1, 1, 1);
    strobe_second(2, 2, 2);
    tick();
    tick();
    tick();
    check("bp_hold_valid", result_valid, 1);
    check("bp_hold_data", result_data, 32);
    check("bp_hold_addr", result_addr, 0);
    result_ready = 1'b1;
    tick();
    check("bp_accept_valid", result_valid, 0);
    wait_result(lat);
    check("bp_second_latency", lat, 4);
    check("bp_second_data", result_data, 6);
    check("bp_second_addr", result_addr, 1);
    tick();
    check("bp_count", result_count, 2);
    check("bp_overrun", overrun, 0);

    // Overrun: a second first-strobe is dropped, the original vector is kept
    do_reset();
    result_ready = 1'b1;
    strobe_first(1, 0, 0);
    check("ovr_clear", overrun, 0);
    strobe_first(9, 9, 9);
    check("ovr_set", overrun, 1);
    strobe_second(5, 0, 0);
    wait_result(lat);
    check("ovr_data", result_data, 5);
    tick();
    check("ovr_sticky", overrun, 1);

    // Same-cycle load/capture: first strobe on the load edge is captured
    do_reset();
    result_ready = 1'b1;
    strobe_first(1, 2, 3);
    strobe_second(4, 5, 6);
    strobe_first(2, 2, 2);
    check("same_busy", busy, 1);
    check("same_overrun", overrun, 0);
    wait_result(lat);
    check("same_first_data", result_data, 32);
    tick();
    strobe_second(3, 3, 3);
    wait_result(lat);
    check("same_second_data", result_data, 18);
    check("same_second_addr", result_addr, 1);
    check("same_overrun_end", overrun, 0);
    tick();

    // Completion: src_done pulsed mid-MAC, all_done waits for the accept
    do_reset();
    result_ready = 1'b1;
    strobe_first(1, 2, 3);
    strobe_second(4, 5, 6);
    tick();
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
    check("done_mac", all_done, 0);
    wait_result(lat);
    check("done_out", all_done, 0);
    tick();
    check("done_final", all_done, 1);
    strobe_first(7, 7, 7);
    check("done_falls", all_done, 0);

    // Reset during MAC abandons the pair
    do_reset();
    result_ready = 1'b1;
    strobe_first(1, 2, 3);
    strobe_second(4, 5, 6);
    tick();
    tick();
    check("rmac_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmac_valid", result_valid, 0);
    check("rmac_busy_after", busy, 0);
    check("rmac_data", result_data, 0);
    check("rmac_count", result_count, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (result_valid) saw_valid = 1'b1;
    end
    check("rmac_no_result", saw_valid, 0);
    strobe_first(1, 1, 1);
    strobe_second(2, 2, 2);
    wait_result(lat);
    check("rmac_next_data", result_data, 6);
    check("rmac_next_addr", result_addr, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_pair_dot_product.md
Name: vector_pair_dot_product

Overview:
- Downstream consumer of the dual vector constructor. Captures first/second vectors on their ready strobes and pairs them in order.
- Computes each pair's unsigned dot product with one multiply-accumulate per cycle.
- Presents each result with a valid/ready handshake and a sequential result address for the result memory writer.
- Reports completion once the constructor signals done and all pairs are drained.

Parameters:
- ELEMENT_WIDTH, 24, bits per vector element (unsigned)
- ADDR_WIDTH, 17, result address width
- VECTOR_DIMENSION, 3, elements per vector (>=1)
- RESULT_WIDTH, 2*ELEMENT_WIDTH+$clog2(VECTOR_DIMENSION+1), accumulator/result width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- first_vector  in  ELEMENT_WIDTH x VECTOR_DIMENSION  first operand vector
- first_vector_ready  in  1  one-cycle strobe: first_vector valid this cycle
- second_vector  in  ELEMENT_WIDTH x VECTOR_DIMENSION  second operand vector
- second_vector_ready  in  1  one-cycle strobe: second_vector valid this cycle
- src_done  in  1  constructor done; level or pulse
- result_data  out  RESULT_WIDTH  dot product
- result_addr  out  ADDR_WIDTH  result index
- result_valid  out  1  result_data/result_addr valid
- result_ready  in  1  consumer accepts the result
- result_count  out  ADDR_WIDTH  results accepted so far
- overrun  out  1  sticky: a vector was dropped
- busy  out  1  state != IDLE
- all_done  out  1  all work complete

Behaviour:
- Reset: reset is synchronous and active-high; clock is clk. On reset:
  - all outputs are 0;
  - holding-register full flags, src_done latch and overrun are cleared;
  - state goes to IDLE.
- Reset mid-MAC or mid-OUT abandons the pair with no result emitted.
- Input capture:
  - Each side has one holding register plus a full flag.
  - A strobe with its side empty captures the vector and sets full.
  - A strobe with its side full drops the new vector, keeps the old one and sets overrun.
  - A strobe in the same cycle the engine drains the holding registers (IDLE load) is captured. It is not an overrun.
- State machine, IDLE / MAC / OUT:
  - IDLE: when both full flags are set at an edge:
    - copy both holding registers into work registers;
    - clear both full flags;
    - acc <= 0, idx <= 0, go to MAC.
  - MAC: each edge does acc <= acc + first[idx]*second[idx] (full-width unsigned, no truncation) and idx <= idx+1. On the edge where idx = VECTOR_DIMENSION-1:
    - result_data <= final sum;
    - result_valid <= 1;
    - go to OUT.
  - OUT: hold result_data, result_addr and result_valid stable until an edge with result_ready=1. At that edge:
    - result_valid <= 0;
    - result_addr and result_count increment (wrap modulo 2^ADDR_WIDTH);
    - go to IDLE.
- Latency: result_valid rises VECTOR_DIMENSION edges after the load edge. Minimum pair period is VECTOR_DIMENSION+2 cycles. The holding registers accept the next pair while the engine computes.
- result_ready while result_valid=0 is ignored.
- src_done: latched sticky at any edge where it is high.
- all_done = latch & both full flags clear & state==IDLE (combinational). It falls if a new strobe arrives afterwards.
- Ordering: results are produced in the order pairs complete. The first vector is always paired with the second vector held at the same time.

Test Plan:
- Basic: DIM=3; first=(1,2,3) strobe, next cycle second=(4,5,6) strobe, result_ready=1 → result_valid 4 edges after second strobe; result_data=32, result_addr=0; result_count=1 after accept.
- Max values: all elements 2^24-1 → result_data=3*(2^24-1)^2 exactly, with no overflow in 50 bits.
- Backpressure: result_ready=0 for 5 cycles after valid; a second pair (1,1,1)·(2,2,2) arrives meanwhile → first result held stable. Then results 32 (addr 0) and 6 (addr 1) in order; overrun=0.
- Overrun: first strobe (1,0,0), then first strobe (9,9,9) before any second strobe, then second (5,0,0) → overrun=1 and result=5.
- Same-cycle load/capture: new first strobe on the IDLE load edge → captured, no overrun; following pair computed correctly.
- Completion/reset: src_done pulse while in MAC → all_done=0 until result accepted, then 1. Separately, assert reset during MAC → no result_valid, all outputs 0, next pair gives addr 0.
